// File: rtl/sb_tx_pkt_scheduler.sv
// sb_tx_pkt_scheduler
//
// Sideband TX packet scheduler, pll_clk domain. Buffers 64-bit sideband
// packets from the message encoder in a DEPTH-entry FIFO and launches them
// one at a time to the TX serializer. Each launch presents the word on
// data_in with a one-cycle data_valid strobe. enable is held high for the
// 64-cycle packet and the following GAP_UI-cycle idle gap. A new launch
// happens only while link_enable is high.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   GAP_UI       idle cycles after each 64-cycle packet (1..128)
//
// Ports:
//   pll_clk      serializer clock, single clock for the block
//   rst          synchronous active-high reset (flushes FIFO, FSM to IDLE)
//   pkt_in       packet word from the encoder
//   pkt_valid    pkt_in valid; pushed when pkt_valid && pkt_ready
//   pkt_ready    FIFO not full (decoded from fifo_count only)
//   link_enable  allows new launches; an in-flight packet/gap always completes
//   data_in      word to the serializer; holds the last launched word
//   data_valid   one-cycle launch strobe
//   enable       serializer enable, high through packet and gap
//   busy         FSM not IDLE or FIFO not empty
//   fifo_count   current FIFO occupancy
//
// Optional feature (macro SB_TX_SCHED_PKT_CNT_EN):
//   pkt_sent_cnt 16-bit wrapping count of launches
module sb_tx_pkt_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GAP_UI = 32
) (
    input  logic                       pll_clk,
    input  logic                       rst,
    input  logic [63:0]                pkt_in,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    input  logic                       link_enable,
    output logic [63:0]                data_in,
    output logic                       data_valid,
    output logic                       enable,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef SB_TX_SCHED_PKT_CNT_EN
    ,
    output logic [15:0]                pkt_sent_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [6:0] SEND_LAST = 7'd63;
    localparam logic [6:0] GAP_LAST  = 7'(GAP_UI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [6:0]    cnt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          launch;

    assign pkt_ready = (fifo_count != CW'(DEPTH));
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign push      = pkt_valid && pkt_ready && !rst;

    // A launch pops the FIFO head; it is possible from IDLE or on the last
    // gap cycle (back-to-back launch without passing through IDLE).
    assign launch = link_enable && (fifo_count != '0) &&
                    ((state == IDLE) || ((state == GAP) && (cnt == GAP_LAST)));

    // Storage needs no reset: the flush is done by clearing pointers/count.
    always_ff @(posedge pll_clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    always_ff @(posedge pll_clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_in    <= '0;
            data_valid <= 1'b0;
            enable     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state      <= SEND;
                        data_in    <= mem[rd_ptr];
                        data_valid <= 1'b1;
                        cnt        <= '0;
                        enable     <= 1'b1;
                    end
                end
                SEND: begin
                    if (cnt == SEND_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (launch) begin
                            state      <= SEND;
                            data_in    <= mem[rd_ptr];
                            data_valid <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            state  <= IDLE;
                            enable <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef SB_TX_SCHED_PKT_CNT_EN
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            pkt_sent_cnt <= '0;
        end else if (launch) begin
            pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sb_tx_pkt_scheduler.sv
// Testbench for sb_tx_pkt_scheduler (default DEPTH=4, GAP_UI=32).
// Table-driven per-cycle vectors followed by hand-written multi-cycle
// sequences: single packet, back-to-back, link drop mid-packet, reset
// mid-SEND, and (with SB_TX_SCHED_PKT_CNT_EN) counter wrap.
module tb_sb_tx_pkt_scheduler;

    logic        pll_clk = 1'b0;
    logic        rst;
    logic [63:0] pkt_in;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        link_enable;
    logic [63:0] data_in;
    logic        data_valid;
    logic        enable;
    logic        busy;
    logic [2:0]  fifo_count;
`ifdef SB_TX_SCHED_PKT_CNT_EN
    logic [15:0] pkt_sent_cnt;
`endif

    sb_tx_pkt_scheduler #(.DEPTH(4), .GAP_UI(32)) dut (
        .pll_clk     (pll_clk),
        .rst         (rst),
        .pkt_in      (pkt_in),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .link_enable (link_enable),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .enable      (enable),
        .busy        (busy),
        .fifo_count  (fifo_count)
`ifdef SB_TX_SCHED_PKT_CNT_EN
        ,
        .pkt_sent_cnt(pkt_sent_cnt)
`endif
    );

    always #5 pll_clk = ~pll_clk;

    int compared   = 0;
    int mismatched = 0;

    // Per-cycle monitor state, updated by step()
    int          cyc = 0;
    int          np = 0;
    int          pulse_t [8];
    logic [63:0] pulse_d [8];
    int          en_cyc = 0;
    int          en_falls = 0;
    logic        prev_en = 1'b0;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [63:0] pkt;
        logic        le;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_dv;
        logic        e_en;
        logic [63:0] e_din;
        logic        e_busy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pll_clk);
        #1;
        cyc++;
        if (data_valid === 1'b1 && np < 8) begin
            pulse_t[np] = cyc;
            pulse_d[np] = data_in;
            np++;
        end
        if (enable === 1'b1) en_cyc++;
        if (prev_en && enable !== 1'b1) en_falls++;
        prev_en = (enable === 1'b1);
    endtask

    task automatic clear_mon();
        np       = 0;
        en_cyc   = 0;
        en_falls = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pkt_valid = 1'b0; link_enable = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [63:0] w);
        pkt_valid = 1'b1; pkt_in = w;
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic wait_en_low(input int budget, input string name);
        int n = 0;
        while (enable === 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (enable !== 1'b0) chk({name, "_timeout"}, {63'd0, enable}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pkt_in = '0; pkt_valid = 1'b0; link_enable = 1'b0;

        //            rst   pv    pkt      le    cnt   rdy   dv    en    din      busy
        vecs[0]  = '{1'b1, 1'b0, 64'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 64'hFF, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 64'h11, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 64'h22, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 64'h33, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 64'h44, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 64'h55, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 64'h66, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 64'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 64'h11, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 64'h00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 64'h11, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 64'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 64'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 64'h77, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 64'h00, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 64'h88, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 64'h77, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 64'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 64'h77, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 64'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; pkt_valid = vecs[i].pv;
            pkt_in = vecs[i].pkt; link_enable = vecs[i].le;
            step();
            chk($sformatf("v%0d_fifo_count", i), {61'd0, fifo_count}, {61'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_pkt_ready", i), {63'd0, pkt_ready}, {63'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_data_valid", i), {63'd0, data_valid}, {63'd0, vecs[i].e_dv});
            chk($sformatf("v%0d_enable", i), {63'd0, enable}, {63'd0, vecs[i].e_en});
            chk($sformatf("v%0d_data_in", i), data_in, vecs[i].e_din);
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
        end
        rst = 1'b0; pkt_valid = 1'b0;

        // Single packet
        do_reset();
        link_enable = 1'b1;
        clear_mon();
        push(64'hA5A5A5A5A5A5A5A5);
        chk("single_count_after_push", {61'd0, fifo_count}, 64'd1);
        chk("single_no_early_dv", {63'd0, data_valid}, 64'd0);
        step();
        chk("single_dv", {63'd0, data_valid}, 64'd1);
        chk("single_din", data_in, 64'hA5A5A5A5A5A5A5A5);
        chk("single_count_after_pop", {61'd0, fifo_count}, 64'd0);
        wait_en_low(200, "single");
        chk("single_en_cycles", 64'(en_cyc), 64'd96);
        chk("single_pulses", 64'(np), 64'd1);
        chk("single_busy_end", {63'd0, busy}, 64'd0);
        chk("single_din_held", data_in, 64'hA5A5A5A5A5A5A5A5);

        // Back-to-back
        do_reset();
        link_enable = 1'b1;
        clear_mon();
        for (int k = 1; k <= 4; k++) push(64'(k));
        // first pop overlaps the second push, so occupancy peaks at 3
        chk("b2b_count_after_pushes", {61'd0, fifo_count}, 64'd3);
        chk("b2b_ready", {63'd0, pkt_ready}, 64'd1);
        wait_en_low(600, "b2b");
        chk("b2b_pulses", 64'(np), 64'd4);
        for (int k = 0; k < 4 && k < np; k++)
            chk($sformatf("b2b_word%0d", k), pulse_d[k], 64'(k + 1));
        for (int k = 0; k < 3 && k + 1 < np; k++)
            chk($sformatf("b2b_period%0d", k), 64'(pulse_t[k+1] - pulse_t[k]), 64'd96);
        chk("b2b_en_cycles", 64'(en_cyc), 64'd384);
        chk("b2b_en_falls", 64'(en_falls), 64'd1);

        // Link drop mid-packet
        do_reset();
        push(64'hC1);
        push(64'hC2);
        chk("drop_count_queued", {61'd0, fifo_count}, 64'd2);
        clear_mon();
        link_enable = 1'b1;
        step();
        chk("drop_launch1", data_in, 64'hC1);
        for (int k = 0; k < 10; k++) step();
        link_enable = 1'b0;
        wait_en_low(200, "drop");
        chk("drop_en_cycles", 64'(en_cyc), 64'd96);
        chk("drop_pulses", 64'(np), 64'd1);
        chk("drop_count_kept", {61'd0, fifo_count}, 64'd1);
        chk("drop_busy", {63'd0, busy}, 64'd1);
        link_enable = 1'b1;
        step();
        chk("drop_relaunch_dv", {63'd0, data_valid}, 64'd1);
        chk("drop_relaunch_din", data_in, 64'hC2);
        chk("drop_relaunch_count", {61'd0, fifo_count}, 64'd0);

        // Reset mid-SEND
        do_reset();
        for (int k = 1; k <= 4; k++) push(64'hD0 + 64'(k));
        link_enable = 1'b1;
        step();
        chk("rst_launch_din", data_in, 64'hD1);
        chk("rst_queued", {61'd0, fifo_count}, 64'd3);
        for (int k = 0; k < 20; k++) step();
        rst = 1'b1;
        step();
        chk("rst_enable", {63'd0, enable}, 64'd0);
        chk("rst_dv", {63'd0, data_valid}, 64'd0);
        chk("rst_din", data_in, 64'd0);
        chk("rst_count", {61'd0, fifo_count}, 64'd0);
        chk("rst_ready", {63'd0, pkt_ready}, 64'd1);
        rst = 1'b0;
        clear_mon();
        for (int k = 0; k < 150; k++) step();
        chk("rst_no_launch", 64'(np), 64'd0);
        chk("rst_no_enable", 64'(en_cyc), 64'd0);
        push(64'hE1);
        step();
        chk("rst_new_launch_dv", {63'd0, data_valid}, 64'd1);
        chk("rst_new_launch_din", data_in, 64'hE1);

`ifdef SB_TX_SCHED_PKT_CNT_EN
        do_reset();
        force dut.pkt_sent_cnt = 16'hFFFF;
        step();
        release dut.pkt_sent_cnt;
        link_enable = 1'b1;
        push(64'hF1);
        step();
        chk("cnt_wrap", {48'd0, pkt_sent_cnt}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sb_tx_pkt_scheduler.md
# sb_tx_pkt_scheduler

Sideband TX packet scheduler that sits directly upstream of the sideband TX serializer in the pll_clk domain. It buffers 64-bit sideband packets from the sideband message encoder in a small FIFO. It launches them one at a time to the serializer, presenting each word with a one-cycle `data_valid` and holding `enable` high. It enforces the mandatory low-idle gap between consecutive packets on TXDATASB.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `GAP_UI`, 32: idle cycles enforced after each 64-cycle packet.
- `pll_clk` in 1: serializer clock (800 MHz); single clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `pkt_in` in 64: packet word from the encoder.
- `pkt_valid` in 1: `pkt_in` is valid.
- `pkt_ready` out 1: FIFO can accept a word.
- `link_enable` in 1: sideband link trained/allowed; gates launching of new packets.
- `data_in` out 64: word to the serializer.
- `data_valid` out 1: one-cycle launch strobe to the serializer.
- `enable` out 1: serializer enable.
- `busy` out 1: state is not IDLE or the FIFO is not empty.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO push:** a word is pushed at a rising edge where `pkt_valid && pkt_ready`.
  - `pkt_ready = (fifo_count != DEPTH)`, combinational from `fifo_count` only; a same-cycle pop does not raise it.
  - Pointers wrap modulo DEPTH.
  - `fifo_count` changes by +1 on push only, −1 on pop only, and 0 on simultaneous push and pop.
- **FSM states:**
  - **IDLE:** if `link_enable && fifo_count != 0`, go to SEND. This transition pops the head: `data_in <= head`, `data_valid <= 1`, `cnt <= 0`, `enable <= 1`.
  - **SEND:** `cnt` counts 0..63.
    - `data_valid` is high only while `cnt == 0`.
    - `data_in` is held stable.
    - At `cnt == 63`, go to GAP with `cnt <= 0`.
  - **GAP:** `cnt` counts 0..GAP_UI-1 and `enable` stays high.
    - At `cnt == GAP_UI-1`: if `link_enable && fifo_count != 0`, pop and go directly to SEND (back-to-back launch, same actions as IDLE→SEND).
    - Otherwise go to IDLE with `enable <= 0`.
- **Sizing:** `cnt` is a 7-bit counter, wide enough for max(64, GAP_UI) ≤ 128. GAP_UI must be at least 1.
- **`link_enable` deasserted mid-SEND or mid-GAP:** the current packet and its gap complete unchanged. No new launch occurs, and the FIFO contents are retained.
- **`data_in`:** holds the last launched word outside SEND.
- **Reset (`rst` high at an edge, any state, including mid-packet):**
  - The FIFO is flushed and state goes to IDLE.
  - All outputs take their reset values on that edge.
  - `pkt_valid` is ignored during reset.

## Timing
- **Reset values:** `data_in` = 0, `data_valid` = 0, `enable` = 0, `busy` = 0, `fifo_count` = 0, `pkt_ready` = 1.
- **Launch latency:**
  - Word accepted at edge N into an empty FIFO in IDLE with `link_enable` = 1: `fifo_count` = 1 after edge N.
  - Launch occurs at edge N+1; `data_valid` and `enable` are high in the cycle after edge N+1, and `fifo_count` returns to 0.
- **Packet period:** consecutive `data_valid` pulses are exactly 64+GAP_UI cycles apart (96 with defaults) when the FIFO stays non-empty.
- **Output registration:** all outputs are registered except `pkt_ready` and `busy`, which decode from registers.

## Configuration
- **Macro:** `SB_TX_SCHED_PKT_CNT_EN`.
- **When defined:** adds output `pkt_sent_cnt` (out, 16). It resets to 0, increments by 1 at every launch edge, and wraps 0xFFFF→0.
- **When undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single packet:** push 64'hA5A5A5A5A5A5A5A5 at edge 0 with `link_enable` = 1 → `data_valid` high for exactly one cycle after edge 1 with `data_in` = A5A5…, `enable` high for 96 cycles, then `enable` = 0, `busy` = 0.
- **Back-to-back:** push 4 words 64'h1, 2, 3, 4 → `pkt_ready` = 0 when `fifo_count` = 4 (the first pop may already have occurred). `data_valid` pulses are 96 cycles apart carrying 1, 2, 3, 4 in order; `enable` stays continuously high from the first launch to the end of the 4th gap.
- **Full FIFO:** hold `pkt_valid` = 1 with `link_enable` = 0 for 6 cycles → exactly 4 words accepted, `pkt_ready` = 0, no `data_valid`. Raising `link_enable` → launch of word 1 on the next edge.
- **Link drop mid-packet:** with 2 words queued, drop `link_enable` at SEND `cnt` = 10 → word 1 finishes its 64+32 cycles, then IDLE with `fifo_count` = 1. Re-raise `link_enable` → word 2 launches one cycle later.
- **Reset mid-SEND:** assert `rst` at SEND `cnt` = 20 with 3 words queued → after that edge `enable` = 0, `data_valid` = 0, `data_in` = 0, `fifo_count` = 0, `pkt_ready` = 1. No launch occurs after release until a new push.
- **With `SB_TX_SCHED_PKT_CNT_EN`:** preload `pkt_sent_cnt` to 0xFFFF (force) and launch one packet → `pkt_sent_cnt` = 0x0000.
